// File: rtl/stack_pc_unit_if.sv
// Sequencer and memory-side signal bundle for stack_pc_unit.
// slave = the unit's view, master = the sequencer/memory environment's view.
interface stack_pc_unit_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              op_valid;
  logic [15:0]       op;
  logic              op_ready;
  logic [31:0]       ret_pc;
  logic [31:0]       target;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  logic [ADDR_W-1:0] sp;
  logic [31:0]       pc_out;
  logic              pc_load;
  logic              busy;
  logic              stack_err;

  modport slave (
    input  op_valid, op, ret_pc, target, mem_rdata, mem_ack,
    output op_ready, mem_req, mem_we, mem_addr, mem_wdata,
           sp, pc_out, pc_load, busy, stack_err
  );

  modport master (
    output op_valid, op, ret_pc, target, mem_rdata, mem_ack,
    input  op_ready, mem_req, mem_we, mem_addr, mem_wdata,
           sp, pc_out, pc_load, busy, stack_err
  );
endinterface

// File: rtl/stack_pc_unit.sv
// Executes call/return micro-ops: PC-half push/pop on a word memory, SP and PC update.
// Optional stack bound checking is enabled by defining STACK_BOUND_CHECK_EN.
module stack_pc_unit #(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SP_INIT  = '1,
  parameter logic [ADDR_W-1:0] SP_LIMIT = '0
) (
  input  logic           clk,
  input  logic           reset,
  stack_pc_unit_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  typedef enum logic [1:0] {
    ACC_PUSH,
    ACC_POP_HI,
    ACC_POP_LO
  } acc_e;

  typedef enum logic [15:0] {
    OP_NOP     = 16'd0,
    OP_PUSH_LO = 16'd1,
    OP_PUSH_HI = 16'd2,
    OP_MOV_LO  = 16'd3,
    OP_MOV_HI  = 16'd4,
    OP_POP_HI  = 16'd5,
    OP_POP_LO  = 16'd6
  } op_e;

`ifdef STACK_BOUND_CHECK_EN
  localparam bit LP_BOUND_EN = 1'b1;
`else
  localparam bit LP_BOUND_EN = 1'b0;
`endif

  // A push at this SP would write below the legal floor.
  localparam logic [ADDR_W-1:0] LP_FLOOR = SP_LIMIT - ADDR_W'(1);

  state_e            r_state, w_state_nxt;
  acc_e              r_acc, w_acc_nxt;
  logic [ADDR_W-1:0] r_sp, w_sp_nxt;
  logic [15:0]       r_ret_hi, w_ret_hi_nxt;
  logic [31:0]       r_pc_buf, w_pc_buf_nxt;
  logic [31:0]       r_pc_out, w_pc_out_nxt;
  logic              r_pc_load, w_pc_load_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [15:0]       r_mem_wdata, w_mem_wdata_nxt;

  logic w_accept;
  logic w_is_push;
  logic w_is_pop;
  logic w_push_blk;
  logic w_pop_blk;

  assign w_accept   = (r_state == ST_IDLE) && bus.op_valid;
  assign w_is_push  = (bus.op == OP_PUSH_LO) || (bus.op == OP_PUSH_HI);
  assign w_is_pop   = (bus.op == OP_POP_HI)  || (bus.op == OP_POP_LO);
  assign w_push_blk = LP_BOUND_EN && (r_sp == LP_FLOOR);
  assign w_pop_blk  = LP_BOUND_EN && (r_sp == SP_INIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= ACC_PUSH;
      r_sp        <= SP_INIT;
      r_ret_hi    <= '0;
      r_pc_buf    <= '0;
      r_pc_out    <= '0;
      r_pc_load   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_sp        <= w_sp_nxt;
      r_ret_hi    <= w_ret_hi_nxt;
      r_pc_buf    <= w_pc_buf_nxt;
      r_pc_out    <= w_pc_out_nxt;
      r_pc_load   <= w_pc_load_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_sp_nxt        = r_sp;
    w_ret_hi_nxt    = r_ret_hi;
    w_pc_buf_nxt    = r_pc_buf;
    w_pc_out_nxt    = r_pc_out;
    w_pc_load_nxt   = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (bus.op)
            OP_PUSH_LO: begin
              if (!w_push_blk) begin
                // Only the upper half is needed later by PUSH_PC_HIGH.
                w_ret_hi_nxt    = bus.ret_pc[31:16];
                w_state_nxt     = ST_ACCESS;
                w_acc_nxt       = ACC_PUSH;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = r_sp;
                w_mem_wdata_nxt = bus.ret_pc[15:0];
              end
            end
            OP_PUSH_HI: begin
              if (!w_push_blk) begin
                w_state_nxt     = ST_ACCESS;
                w_acc_nxt       = ACC_PUSH;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = r_sp;
                w_mem_wdata_nxt = r_ret_hi;
              end
            end
            OP_MOV_LO: begin
              w_pc_buf_nxt[15:0] = bus.target[15:0];
            end
            OP_MOV_HI: begin
              w_pc_out_nxt  = {bus.target[31:16], r_pc_buf[15:0]};
              w_pc_load_nxt = 1'b1;
            end
            OP_POP_HI, OP_POP_LO: begin
              if (!w_pop_blk) begin
                w_state_nxt    = ST_ACCESS;
                w_acc_nxt      = (bus.op == OP_POP_HI) ? ACC_POP_HI : ACC_POP_LO;
                w_mem_we_nxt   = 1'b0;
                w_mem_addr_nxt = r_sp + ADDR_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      ST_ACCESS: begin
        if (bus.mem_ack) begin
          w_state_nxt = ST_IDLE;
          case (r_acc)
            ACC_PUSH: w_sp_nxt = r_sp - ADDR_W'(1);
            ACC_POP_HI: begin
              w_sp_nxt              = r_sp + ADDR_W'(1);
              w_pc_buf_nxt[31:16]   = bus.mem_rdata;
            end
            ACC_POP_LO: begin
              w_sp_nxt      = r_sp + ADDR_W'(1);
              w_pc_out_nxt  = {r_pc_buf[31:16], bus.mem_rdata};
              w_pc_load_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef STACK_BOUND_CHECK_EN
  logic r_stack_err;
  logic w_err_set;

  assign w_err_set = w_accept && ((w_is_push && w_push_blk) || (w_is_pop && w_pop_blk));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stack_err <= 1'b0;
    end else if (w_err_set) begin
      r_stack_err <= 1'b1;
    end
  end

  assign bus.stack_err = r_stack_err;
`else
  logic w_unused_decode;
  assign w_unused_decode = w_is_push ^ w_is_pop;
  assign bus.stack_err   = 1'b0 & w_unused_decode;
`endif

  assign bus.op_ready  = (r_state == ST_IDLE);
  assign bus.mem_req   = (r_state == ST_ACCESS);
  assign bus.busy      = (r_state == ST_ACCESS);
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.sp        = r_sp;
  assign bus.pc_out    = r_pc_out;
  assign bus.pc_load   = r_pc_load;

endmodule
